// File: rtl/hack_loader_pkg.sv
// Shared types and constants for the Hack ROM byte-stream loader.
// Frame layout is big-endian: length high byte, length low byte, then words HI/LO.
package hack_loader_pkg;

    localparam int LOADER_WORD_W = 16;
    localparam int LOADER_BYTE_W = 8;

    // Position of each length byte within the frame header.
    localparam int HDR_LEN_HI_POS = 0;
    localparam int HDR_LEN_LO_POS = 1;
    localparam int HDR_BYTES      = 2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_RST_REQ,
        ST_RST_REL,
        ST_BYTE_HI,
        ST_BYTE_LO,
        ST_LOAD,
        ST_LOAD_REL,
        ST_DONE,
        ST_ERROR,
        ST_CHK_HI,
        ST_CHK_LO
    } loader_state_t;

    function automatic logic [LOADER_WORD_W-1:0] be_word(
        input logic [LOADER_BYTE_W-1:0] hi,
        input logic [LOADER_BYTE_W-1:0] lo
    );
        return {hi, lo};
    endfunction

    // States that wait on the SoC and are therefore bounded by the timeout.
    function automatic logic is_wait_state(input loader_state_t s);
        return (s == ST_RST_REQ) || (s == ST_RST_REL) ||
               (s == ST_LOAD)    || (s == ST_LOAD_REL);
    endfunction

    function automatic logic accepts_bytes(input loader_state_t s);
        return (s == ST_IDLE)    || (s == ST_LEN_HI)  || (s == ST_LEN_LO) ||
               (s == ST_BYTE_HI) || (s == ST_BYTE_LO) ||
               (s == ST_CHK_HI)  || (s == ST_CHK_LO);
    endfunction

endpackage

// File: rtl/loader_handshake_timer.sv
// Cycle counter for SoC handshake waits; flags a timeout on the ACK_TIMEOUT-th
// cycle spent in a wait state without a response. Restarts on any state change.
module loader_handshake_timer #(
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic enable,
    output logic timeout
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    // count_reg holds the number of completed cycles already spent waiting.
    assign timeout = enable && (count_reg == CNT_W'(ACK_TIMEOUT - 1));

    always_comb begin
        count_next = count_reg;
        if (restart || !enable) begin
            count_next = '0;
        end else if (!timeout) begin
            count_next = count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/uart_rom_stream_loader.sv
// Byte-stream front end for the Hack SoC ROM loader: assembles big-endian words and
// drives the rom_loader_* handshake. Define UART_ROM_LOADER_CHECKSUM_EN for a trailing 16-bit sum.
module uart_rom_stream_loader
    import hack_loader_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int MAX_WORDS   = 32768,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [LOADER_BYTE_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     rom_loader_reset,
    output logic                     rom_loader_load,
    output logic [DATA_WIDTH-1:0]    rom_loader_data,
    input  logic                     rom_loader_ack,
    input  logic                     rom_loader_load_received,
    output logic                     hack_external_reset,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [LOADER_WORD_W-1:0] words_loaded
);

    loader_state_t             state_reg, state_next;
    logic                      in_ready_reg, in_ready_next;
    logic [LOADER_WORD_W-1:0]  len_reg, len_next;
    logic [DATA_WIDTH-1:0]     data_reg, data_next;
    logic [LOADER_WORD_W-1:0]  words_reg, words_next;
    logic                      busy_reg, busy_next;
    logic                      done_reg, done_next;
    logic                      error_reg, error_next;
    logic                      hack_reset_reg, hack_reset_next;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
    logic [LOADER_WORD_W-1:0]  sum_reg, sum_next;
    logic [LOADER_BYTE_W-1:0]  chk_hi_reg, chk_hi_next;
`endif

    logic                      accept;
    logic                      ack_timeout;
    logic                      state_change;
    logic                      in_wait;
    logic [LOADER_WORD_W-1:0]  len_word;
    logic [31:0]               len_wide;
    logic [LOADER_WORD_W-1:0]  words_inc;

    assign accept       = in_valid && in_ready_reg;
    assign state_change = (state_next != state_reg);
    assign in_wait      = is_wait_state(state_reg);

    loader_handshake_timer #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .restart(state_change),
        .enable (in_wait),
        .timeout(ack_timeout)
    );

    always_comb begin
        state_next      = state_reg;
        len_next        = len_reg;
        data_next       = data_reg;
        words_next      = words_reg;
        busy_next       = busy_reg;
        done_next       = done_reg;
        error_next      = error_reg;
        hack_reset_next = hack_reset_reg;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
        sum_next        = sum_reg;
        chk_hi_next     = chk_hi_reg;
`endif
        len_word        = be_word(len_reg[LOADER_WORD_W-1:LOADER_BYTE_W], in_data);
        len_wide        = {16'h0000, len_word};
        words_inc       = words_reg + 16'd1;

        case (state_reg)
            // IDLE consumes the length high byte directly; LEN_HI behaves the same.
            ST_IDLE, ST_LEN_HI: begin
                if (accept) begin
                    len_next        = be_word(in_data, 8'h00);
                    done_next       = 1'b0;
                    error_next      = 1'b0;
                    words_next      = '0;
                    busy_next       = 1'b1;
                    hack_reset_next = 1'b1;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
                    sum_next        = '0;
`endif
                    state_next      = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    len_next = len_word;
                    if (len_wide > 32'(MAX_WORDS)) begin
                        state_next = ST_ERROR;
                    end else if (len_word == '0) begin
`ifdef UART_ROM_LOADER_CHECKSUM_EN
                        state_next = ST_CHK_HI;
`else
                        state_next = ST_DONE;
`endif
                    end else begin
                        state_next = ST_RST_REQ;
                    end
                end
            end
            ST_RST_REQ: begin
                if (rom_loader_ack) begin
                    state_next = ST_RST_REL;
                end else if (ack_timeout) begin
                    state_next = ST_ERROR;
                end
            end
            ST_RST_REL: begin
                if (!rom_loader_ack) begin
                    state_next = ST_BYTE_HI;
                end else if (ack_timeout) begin
                    state_next = ST_ERROR;
                end
            end
            ST_BYTE_HI: begin
                if (accept) begin
                    data_next  = be_word(in_data, data_reg[LOADER_BYTE_W-1:0]);
                    state_next = ST_BYTE_LO;
                end
            end
            ST_BYTE_LO: begin
                if (accept) begin
                    data_next  = be_word(data_reg[LOADER_WORD_W-1:LOADER_BYTE_W], in_data);
`ifdef UART_ROM_LOADER_CHECKSUM_EN
                    sum_next   = sum_reg + data_next;
`endif
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (rom_loader_load_received) begin
                    state_next = ST_LOAD_REL;
                end else if (ack_timeout) begin
                    state_next = ST_ERROR;
                end
            end
            ST_LOAD_REL: begin
                if (!rom_loader_load_received) begin
                    words_next = words_inc;
                    if (words_inc == len_reg) begin
`ifdef UART_ROM_LOADER_CHECKSUM_EN
                        state_next = ST_CHK_HI;
`else
                        state_next = ST_DONE;
`endif
                    end else begin
                        state_next = ST_BYTE_HI;
                    end
                end else if (ack_timeout) begin
                    state_next = ST_ERROR;
                end
            end
`ifdef UART_ROM_LOADER_CHECKSUM_EN
            ST_CHK_HI: begin
                if (accept) begin
                    chk_hi_next = in_data;
                    state_next  = ST_CHK_LO;
                end
            end
            ST_CHK_LO: begin
                if (accept) begin
                    state_next = (be_word(chk_hi_reg, in_data) == sum_reg) ? ST_DONE : ST_ERROR;
                end
            end
`endif
            ST_DONE:  state_next = ST_IDLE;
            ST_ERROR: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase

        // Completion flags are applied on entry so they appear with the new state.
        if (state_next == ST_DONE) begin
            done_next       = 1'b1;
            busy_next       = 1'b0;
            hack_reset_next = 1'b0;
        end
        if (state_next == ST_ERROR) begin
            error_next = 1'b1;
            busy_next  = 1'b0;
            data_next  = '0;
        end

        in_ready_next = accepts_bytes(state_next);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            in_ready_reg   <= 1'b0;
            len_reg        <= '0;
            data_reg       <= '0;
            words_reg      <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
            hack_reset_reg <= 1'b1;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
            sum_reg        <= '0;
            chk_hi_reg     <= '0;
`endif
        end else begin
            state_reg      <= state_next;
            in_ready_reg   <= in_ready_next;
            len_reg        <= len_next;
            data_reg       <= data_next;
            words_reg      <= words_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            error_reg      <= error_next;
            hack_reset_reg <= hack_reset_next;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
            sum_reg        <= sum_next;
            chk_hi_reg     <= chk_hi_next;
`endif
        end
    end

    assign in_ready            = in_ready_reg;
    assign rom_loader_reset    = (state_reg == ST_RST_REQ);
    assign rom_loader_load     = (state_reg == ST_LOAD);
    assign rom_loader_data     = data_reg;
    assign hack_external_reset = hack_reset_reg;
    assign busy                = busy_reg;
    assign done                = done_reg;
    assign error               = error_reg;
    assign words_loaded        = words_reg;

endmodule
